// File: rtl/altitude_pkg.sv
// Shared types for the altitude front-end: flight-mode encodings and the mode transition rule.
package altitude_pkg;

  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    S_BEKLE = 2'd0,
    S_CALIS = 2'd1,
    S_KISMI = 2'd2,
    S_HATA  = 2'd3
  } state_t;

  // Mode follows sensor freshness; leaving S_BEKLE needs both sensors, leaving S_HATA needs one.
  function automatic state_t next_state(input state_t s, input logic g_ok, input logic a_ok);
    state_t n;
    n = s;
    case (s)
      S_BEKLE: n = (g_ok && a_ok) ? S_CALIS : S_BEKLE;
      S_HATA:  n = (g_ok || a_ok) ? S_KISMI : S_HATA;
      default: n = (g_ok && a_ok) ? S_CALIS : ((g_ok || a_ok) ? S_KISMI : S_HATA);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One altitude sensor: moving-average ring buffer with preload on first sample,
// staleness watchdog, and a registered filtered value one cycle after the update.
module sensor_channel
  import altitude_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned AVG_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] filt,
  output logic              upd,
  output logic              fresh,
  output logic              stale
);

  localparam int unsigned AVG_SH = $clog2(AVG_DEPTH);
  localparam int unsigned SUM_W  = DATA_W + AVG_SH;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);

  logic [DATA_W-1:0] ring_q [AVG_DEPTH];
  logic [AVG_SH-1:0] ptr_q;
  logic [SUM_W-1:0]  sum_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              filled_q;
  logic              upd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(AVG_DEPTH); i++) ring_q[i] <= '0;
      ptr_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      filled_q <= 1'b0;
      upd_q    <= 1'b0;
      stale    <= 1'b0;
      filt     <= '0;
      upd      <= 1'b0;
      fresh    <= 1'b0;
    end else begin
      upd_q <= sample_valid;
      filt  <= DATA_W'(sum_q >> AVG_SH);
      upd   <= upd_q;
      fresh <= filled_q;
      if (sample_valid) begin
        cnt_q    <= '0;
        stale    <= 1'b0;
        filled_q <= 1'b1;
        if (!filled_q) begin
          // Empty channel: seed the whole window so the average is valid at once.
          for (int i = 0; i < int'(AVG_DEPTH); i++) ring_q[i] <= sample;
          sum_q <= SUM_W'(sample) << AVG_SH;
        end else begin
          ring_q[ptr_q] <= sample;
          sum_q         <= sum_q - SUM_W'(ring_q[ptr_q]) + SUM_W'(sample);
          ptr_q         <= ptr_q + AVG_SH'(1);
        end
      end else if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
        cnt_q <= cnt_q + CNT_W'(1);
        // Going stale also empties the window so the next sample re-seeds it.
        if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          stale    <= 1'b1;
          filled_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/altitude_sensor_filter.sv
// Altitude front-end: two filtered sensor channels, GNSS/altimeter fusion,
// flight-mode tracking and health flags; ortalama_o/veri_hazir_o lag a sample by two cycles.
module altitude_sensor_filter
  import altitude_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned AVG_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned MAX_DIFF    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] gnss_i,
  input  logic              gnss_valid_i,
  input  logic [DATA_W-1:0] altimetre_i,
  input  logic              altimetre_valid_i,
  output logic [DATA_W-1:0] gnss_o,
  output logic [DATA_W-1:0] altimetre_o,
  output logic [DATA_W-1:0] ortalama_o,
  output logic              veri_hazir_o,
  output logic              gnss_asim_o,
  output logic              altimetre_asim_o,
  output logic              sensor_hata_o
);

  logic        g_upd, a_upd, g_fresh, a_fresh;
  logic [DATA_W:0]   pair_sum_c;
  logic [DATA_W-1:0] diff_c;
  logic [DATA_W-1:0] fused_c;
  state_t      state_q, state_n_c;
  logic        pulse_c;

  sensor_channel #(
    .DATA_W(DATA_W), .AVG_DEPTH(AVG_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gnss (
    .clk(clk), .rst_n(rst_n), .sample(gnss_i), .sample_valid(gnss_valid_i),
    .filt(gnss_o), .upd(g_upd), .fresh(g_fresh), .stale(gnss_asim_o)
  );

  sensor_channel #(
    .DATA_W(DATA_W), .AVG_DEPTH(AVG_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_altimetre (
    .clk(clk), .rst_n(rst_n), .sample(altimetre_i), .sample_valid(altimetre_valid_i),
    .filt(altimetre_o), .upd(a_upd), .fresh(a_fresh), .stale(altimetre_asim_o)
  );

  // Fusion: average when sensors agree, trust GNSS on disagreement, else the fresh one.
  always_comb begin
    pair_sum_c = {1'b0, gnss_o} + {1'b0, altimetre_o};
    diff_c     = (gnss_o >= altimetre_o) ? (gnss_o - altimetre_o) : (altimetre_o - gnss_o);
    fused_c    = ortalama_o;
    if (g_fresh && a_fresh) begin
      fused_c = (diff_c > DATA_W'(MAX_DIFF)) ? gnss_o : DATA_W'(pair_sum_c >> 1);
    end else if (g_fresh) begin
      fused_c = gnss_o;
    end else if (a_fresh) begin
      fused_c = altimetre_o;
    end
    state_n_c = next_state(state_q, g_fresh, a_fresh);
    pulse_c   = (g_upd || a_upd) && ((state_n_c == S_CALIS) || (state_n_c == S_KISMI));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_BEKLE;
      ortalama_o    <= '0;
      veri_hazir_o  <= 1'b0;
      sensor_hata_o <= 1'b0;
    end else begin
      state_q       <= state_n_c;
      veri_hazir_o  <= pulse_c;
      sensor_hata_o <= (state_n_c != S_CALIS);
      if (pulse_c) ortalama_o <= fused_c;
    end
  end

endmodule

// File: tb/tb_altitude_sensor_filter.sv
// Directed bench for altitude_sensor_filter with a cycle-level reference model checked every cycle.
module tb_altitude_sensor_filter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned AVG    = 4;
  localparam int unsigned T      = 1000;
  localparam int unsigned MAXD   = 9;
  localparam int M_WAIT = 0, M_RUN = 1, M_PART = 2, M_FAULT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] gnss_i = '0, altimetre_i = '0;
  logic              gnss_valid_i = 1'b0, altimetre_valid_i = 1'b0;
  logic [DATA_W-1:0] gnss_o, altimetre_o, ortalama_o;
  logic              veri_hazir_o, gnss_asim_o, altimetre_asim_o, sensor_hata_o;

  int n_checks = 0;
  int n_errors = 0;

  altitude_sensor_filter #(
    .DATA_W(DATA_W), .AVG_DEPTH(AVG), .TIMEOUT_CYC(T), .MAX_DIFF(MAXD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .gnss_i(gnss_i), .gnss_valid_i(gnss_valid_i),
    .altimetre_i(altimetre_i), .altimetre_valid_i(altimetre_valid_i),
    .gnss_o(gnss_o), .altimetre_o(altimetre_o), .ortalama_o(ortalama_o),
    .veri_hazir_o(veri_hazir_o), .gnss_asim_o(gnss_asim_o),
    .altimetre_asim_o(altimetre_asim_o), .sensor_hata_o(sensor_hata_o)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 = GNSS, 1 = altimeter; hist[c][0] is the newest sample.
  bit          in_v[2];
  int unsigned in_s[2];
  int unsigned hist[2][AVG];
  bit          m_fill[2], m_stale[2], m_upd[2];
  int unsigned m_idle[2];
  int unsigned s1_filt[2];
  bit          s1_upd[2], s1_fresh[2];
  int unsigned m_ort;
  bit          m_veri, m_hata;
  int          mode;

  function automatic int unsigned hist_avg(input int c);
    int unsigned s;
    s = 0;
    for (int k = 0; k < int'(AVG); k++) s += hist[c][k];
    return s / AVG;
  endfunction

  task automatic model_edge();
    int nxt;
    bit pulse, both, any;
    int unsigned g, a, d;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < int'(AVG); k++) hist[c][k] = 0;
        m_fill[c] = 0; m_stale[c] = 0; m_upd[c] = 0; m_idle[c] = 0;
        s1_filt[c] = 0; s1_upd[c] = 0; s1_fresh[c] = 0;
      end
      m_ort = 0; m_veri = 0; m_hata = 0; mode = M_WAIT;
      return;
    end
    both = s1_fresh[0] && s1_fresh[1];
    any  = s1_fresh[0] || s1_fresh[1];
    if (mode == M_WAIT)       nxt = both ? M_RUN : M_WAIT;
    else if (mode == M_FAULT) nxt = any ? M_PART : M_FAULT;
    else                      nxt = both ? M_RUN : (any ? M_PART : M_FAULT);
    pulse = (s1_upd[0] || s1_upd[1]) && (nxt == M_RUN || nxt == M_PART);
    if (pulse) begin
      g = s1_filt[0];
      a = s1_filt[1];
      if (both) begin
        d = (g > a) ? g - a : a - g;
        m_ort = (d > MAXD) ? g : (g + a) / 2;
      end else if (s1_fresh[0]) m_ort = g;
      else m_ort = a;
    end
    m_veri = pulse;
    m_hata = (nxt != M_RUN);
    mode   = nxt;
    for (int c = 0; c < 2; c++) begin
      s1_filt[c]  = hist_avg(c);
      s1_upd[c]   = m_upd[c];
      s1_fresh[c] = m_fill[c];
    end
    for (int c = 0; c < 2; c++) begin
      if (in_v[c]) begin
        if (!m_fill[c]) begin
          for (int k = 0; k < int'(AVG); k++) hist[c][k] = in_s[c];
        end else begin
          for (int k = int'(AVG) - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
          hist[c][0] = in_s[c];
        end
        m_fill[c] = 1; m_stale[c] = 0; m_idle[c] = 0; m_upd[c] = 1;
      end else begin
        m_upd[c] = 0;
        if (m_idle[c] < T) begin
          m_idle[c]++;
          if (m_idle[c] == T) begin
            m_stale[c] = 1;
            m_fill[c]  = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("gnss_o", 32'(gnss_o), s1_filt[0]);
    check("altimetre_o", 32'(altimetre_o), s1_filt[1]);
    check("ortalama_o", 32'(ortalama_o), m_ort);
    check("veri_hazir_o", 32'(veri_hazir_o), 32'(m_veri));
    check("gnss_asim_o", 32'(gnss_asim_o), 32'(m_stale[0]));
    check("altimetre_asim_o", 32'(altimetre_asim_o), 32'(m_stale[1]));
    check("sensor_hata_o", 32'(sensor_hata_o), 32'(m_hata));
  endtask

  task automatic step(input bit gv, input int unsigned g, input bit av, input int unsigned a);
    gnss_valid_i      = gv;
    gnss_i            = DATA_W'(g);
    altimetre_valid_i = av;
    altimetre_i       = DATA_W'(a);
    in_v[0] = gv; in_s[0] = g & 32'hFFFF;
    in_v[1] = av; in_s[1] = a & 32'hFFFF;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int unsigned avg_in[5]  = '{104, 108, 112, 100, 100};
  int unsigned avg_exp[5] = '{101, 103, 106, 106, 105};

  initial begin
    rst_n = 1'b0;
    idle(3);
    check("pin_reset_gnss_o", 32'(gnss_o), 0);
    check("pin_reset_ortalama_o", 32'(ortalama_o), 0);
    check("pin_reset_flags", {28'd0, veri_hazir_o, gnss_asim_o, altimetre_asim_o, sensor_hata_o}, 0);
    rst_n = 1'b1;

    // First pair preloads both windows; fused value and pulse two cycles later.
    step(1, 100, 1, 104);
    idle(1);
    check("pin_first_gnss_o", 32'(gnss_o), 100);
    check("pin_first_altimetre_o", 32'(altimetre_o), 104);
    idle(1);
    check("pin_first_ortalama_o", 32'(ortalama_o), 102);
    check("pin_first_veri_hazir", 32'(veri_hazir_o), 1);
    check("pin_first_sensor_hata", 32'(sensor_hata_o), 0);
    idle(1);
    check("pin_first_pulse_end", 32'(veri_hazir_o), 0);

    // Moving average over the preloaded GNSS window.
    for (int i = 0; i < 5; i++) begin
      step(1, avg_in[i], 0, 0);
      idle(1);
      check($sformatf("pin_avg_%0d", i), 32'(gnss_o), avg_exp[i]);
    end

    // Full-rate burst on both channels, then mixed single-channel strobes.
    for (int i = 0; i < 20; i++) step(1, 300 + i * 3, 1, 295 + (i * 7) % 20);
    for (int i = 0; i < 12; i++) step(i % 2 == 0, 320 - i, i % 3 == 0, 310 + i);
    idle(3);

    // Disagreement above MAX_DIFF falls back to GNSS; exactly MAX_DIFF averages.
    do_reset();
    step(1, 200, 1, 180);
    idle(2);
    check("pin_diff20_ortalama", 32'(ortalama_o), 200);
    do_reset();
    step(1, 200, 1, 191);
    idle(2);
    check("pin_diff9_ortalama", 32'(ortalama_o), 195);
    check("pin_diff9_veri", 32'(veri_hazir_o), 1);

    // Altimeter goes silent while GNSS keeps arriving.
    step(1, 195, 1, 191);
    for (int k = 1; k <= int'(T) + 12; k++) begin
      step(k % 10 == 0, 195, 0, 0);
      if (k == int'(T) - 1) check("pin_stale_before", 32'(altimetre_asim_o), 0);
      if (k == int'(T))     check("pin_stale_at_timeout", 32'(altimetre_asim_o), 1);
    end
    check("pin_partial_veri", 32'(veri_hazir_o), 1);
    check("pin_partial_ortalama", 32'(ortalama_o), 195);
    check("pin_partial_hata", 32'(sensor_hata_o), 1);
    step(0, 0, 1, 150);
    check("pin_stale_cleared", 32'(altimetre_asim_o), 0);
    idle(2);
    check("pin_recovered_hata", 32'(sensor_hata_o), 0);

    // Both sensors silent: fault mode, outputs hold.
    idle(int'(T) + 10);
    check("pin_fault_gnss_asim", 32'(gnss_asim_o), 1);
    check("pin_fault_alt_asim", 32'(altimetre_asim_o), 1);
    check("pin_fault_hold_gnss", 32'(gnss_o), 195);
    check("pin_fault_hold_alt", 32'(altimetre_o), 150);
    check("pin_fault_hold_ortalama", 32'(ortalama_o), 195);
    check("pin_fault_hata", 32'(sensor_hata_o), 1);

    // One sensor returns: re-preload and degraded mode.
    step(1, 120, 0, 0);
    idle(2);
    check("pin_revive_ortalama", 32'(ortalama_o), 120);
    check("pin_revive_hata", 32'(sensor_hata_o), 1);

    // Reset in the middle of traffic.
    step(1, 130, 1, 131);
    step(1, 132, 1, 133);
    rst_n = 1'b0;
    step(1, 140, 1, 141);
    check("pin_midreset_gnss_o", 32'(gnss_o), 0);
    check("pin_midreset_ortalama", 32'(ortalama_o), 0);
    check("pin_midreset_flags", {28'd0, veri_hazir_o, gnss_asim_o, altimetre_asim_o, sensor_hata_o}, 0);
    rst_n = 1'b1;
    idle(2);
    check("pin_after_reset_gnss_o", 32'(gnss_o), 0);
    check("pin_after_reset_hata", 32'(sensor_hata_o), 1);

    // Full-scale samples exercise the widest sum and the fusion carry.
    for (int i = 0; i < 4; i++) step(1, 16'hFFFF, 1, 16'hFFFF);
    idle(2);
    check("pin_max_ortalama", 32'(ortalama_o), 32'hFFFF);
    check("pin_max_gnss_o", 32'(gnss_o), 32'hFFFF);
    check("pin_max_alt_o", 32'(altimetre_o), 32'hFFFF);
    step(1, 16'hFFFF, 1, 16'hFFFA);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
